fib_sequencer: RTL and testbench

FIB_SEQUENCER -- requirements
Module: fib_sequencer

---
 rtl/fib_pkg.sv | 48 ++++
 rtl/fib_datapath.sv | 90 +++++++++
 rtl/fib_sequencer.sv | 89 ++++++++
 tb/tb_fib_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer and its datapath.
// Holds widths, stack sizing, the one-hot state encoding and the control bundle.
package fib_pkg;

    localparam int N_W       = 3;
    localparam int RES_W     = 5;
    localparam int MAX_N     = 7;
    localparam int STK_DEPTH = 8;
    localparam int PTR_W     = $clog2(STK_DEPTH);
    localparam int SP_W      = $clog2(STK_DEPTH + 1);

    // One-hot bit positions; outputs are taken straight from these flops.
    localparam int unsigned B_IDLE    = 0;
    localparam int unsigned B_CLEAR   = 1;
    localparam int unsigned B_INIT    = 2;
    localparam int unsigned B_CHECK   = 3;
    localparam int unsigned B_LEAF    = 4;
    localparam int unsigned B_EXP_POP = 5;
    localparam int unsigned B_EXP_A   = 6;
    localparam int unsigned B_EXP_B   = 7;
    localparam int unsigned B_DONE    = 8;

    localparam int ST_W = 9;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = 9'b0_0000_0001,
        S_CLEAR   = 9'b0_0000_0010,
        S_INIT    = 9'b0_0000_0100,
        S_CHECK   = 9'b0_0000_1000,
        S_LEAF    = 9'b0_0001_0000,
        S_EXP_POP = 9'b0_0010_0000,
        S_EXP_A   = 9'b0_0100_0000,
        S_EXP_B   = 9'b0_1000_0000,
        S_DONE    = 9'b1_0000_0000
    } state_e;

    typedef struct packed {
        logic dp_rst;
        logic ins;
        logic push;
        logic pop;
        logic modes;
        logic cntup;
        logic busy;
        logic done;
    } ctrl_t;

endpackage

// File: rtl/fib_datapath.sv
// Stack/temp/result datapath driven by fib_sequencer.
// Ports: clk, rst (async high), dp_rst, ins, push, pop, modes, cntup, n;
// lt/empty flags back to the sequencer; result holds the running sum.
module fib_datapath
    import fib_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             dp_rst,
    input  logic             ins,
    input  logic             push,
    input  logic             pop,
    input  logic             modes,
    input  logic             cntup,
    input  logic [N_W-1:0]   n,
    output logic             lt,
    output logic             empty,
    output logic [RES_W-1:0] result
);

    logic [N_W-1:0]   stk_q [STK_DEPTH];
    logic [N_W-1:0]   stk_d [STK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [N_W-1:0]   tmp_q;
    logic [N_W-1:0]   tmp_d;
    logic [RES_W-1:0] res_q;
    logic [RES_W-1:0] res_d;

    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic [N_W-1:0]   top;
    logic [N_W-1:0]   push_val;

    assign top_idx = PTR_W'(sp_q - SP_W'(1));
    assign wr_idx  = PTR_W'(sp_q);
    assign top     = stk_q[top_idx];
    assign empty   = (sp_q == '0);
    assign lt      = (top < N_W'(2));
    assign result  = res_q;

    // Children of node k are k-1 then k-2, so k-2 is expanded first.
    assign push_val = ins   ? n :
                      modes ? tmp_q - N_W'(2) :
                              tmp_q - N_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
            sp_q  <= '0;
            tmp_q <= '0;
            res_q <= '0;
        end else begin
            stk_q <= stk_d;
            sp_q  <= sp_d;
            tmp_q <= tmp_d;
            res_q <= res_d;
        end
    end

    always_comb begin
        stk_d = stk_q;
        sp_d  = sp_q;
        tmp_d = tmp_q;
        res_d = res_q;
        if (dp_rst) begin
            for (int i = 0; i < STK_DEPTH; i++) begin
                stk_d[i] = '0;
            end
            sp_d  = '0;
            tmp_d = '0;
            res_d = '0;
        end else begin
            // A leaf is 0 or 1, so adding the top value sums fib(n).
            if (cntup) begin
                res_d = res_q + RES_W'(top);
            end
            if (pop) begin
                tmp_d = top;
                sp_d  = sp_q - SP_W'(1);
            end else if (push) begin
                stk_d[wr_idx] = push_val;
                sp_d          = sp_q + SP_W'(1);
            end
        end
    end

endmodule

// File: rtl/fib_sequencer.sv
// Control FSM computing fib(n) by depth-first expansion on an external stack.
// Ports: clk, rst (async high), start, lt/empty from datapath;
// dp_rst, ins, push, pop, modes, cntup to datapath; busy, done status.
module fib_sequencer
    import fib_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic lt,
    input  logic empty,
    output logic dp_rst,
    output logic ins,
    output logic push,
    output logic pop,
    output logic modes,
    output logic cntup,
    output logic busy,
    output logic done
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR:   state_d = S_INIT;
            S_INIT:    state_d = S_CHECK;
            S_CHECK: begin
                // An empty stack means every leaf has been summed.
                if (empty) begin
                    state_d = S_DONE;
                end else if (lt) begin
                    state_d = S_LEAF;
                end else begin
                    state_d = S_EXP_POP;
                end
            end
            S_LEAF:    state_d = S_CHECK;
            S_EXP_POP: state_d = S_EXP_A;
            S_EXP_A:   state_d = S_EXP_B;
            S_EXP_B:   state_d = S_CHECK;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Each output is an OR of one-hot state bits, so nothing from the
    // inputs can reach the outputs and dp_rst is a bare flop output.
    always_comb begin
        ctrl        = '0;
        ctrl.dp_rst = state_q[B_CLEAR];
        ctrl.ins    = state_q[B_INIT];
        ctrl.push   = state_q[B_INIT]
                    | state_q[B_EXP_A]
                    | state_q[B_EXP_B];
        ctrl.pop    = state_q[B_LEAF]
                    | state_q[B_EXP_POP];
        ctrl.modes  = state_q[B_EXP_B];
        ctrl.cntup  = state_q[B_LEAF];
        ctrl.busy   = ~state_q[B_IDLE];
        ctrl.done   = state_q[B_DONE];
    end

    assign dp_rst = ctrl.dp_rst;
    assign ins    = ctrl.ins;
    assign push   = ctrl.push;
    assign pop    = ctrl.pop;
    assign modes  = ctrl.modes;
    assign cntup  = ctrl.cntup;
    assign busy   = ctrl.busy;
    assign done   = ctrl.done;

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed bench for fib_sequencer paired with fib_datapath.
// Checks reset, latencies, results, output traces, ignored start and abort.
module tb_fib_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] n;
    logic       lt;
    logic       empty;
    logic       dp_rst;
    logic       ins;
    logic       push;
    logic       pop;
    logic       modes;
    logic       cntup;
    logic       busy;
    logic       done;
    logic [4:0] result;
    logic [7:0] ctl;

    int n_cmp;
    int n_bad;
    int pushes;
    int pops;
    int busy_lows;
    int res_at_done;
    int dc;
    int trace [1:16];

    localparam int C_IDLE  = 8'b0000_0000;
    localparam int C_CLEAR = 8'b1000_0010;
    localparam int C_INIT  = 8'b0110_0010;
    localparam int C_CHECK = 8'b0000_0010;
    localparam int C_POP   = 8'b0001_0010;
    localparam int C_EXPA  = 8'b0010_0010;
    localparam int C_EXPB  = 8'b0010_1010;
    localparam int C_LEAF  = 8'b0001_0110;
    localparam int C_DONE  = 8'b0000_0011;

    assign ctl = {dp_rst, ins, push, pop, modes, cntup, busy, done};

    fib_sequencer u_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .lt     (lt),
        .empty  (empty),
        .dp_rst (dp_rst),
        .ins    (ins),
        .push   (push),
        .pop    (pop),
        .modes  (modes),
        .cntup  (cntup),
        .busy   (busy),
        .done   (done)
    );

    fib_datapath u_dp (
        .clk    (clk),
        .rst    (rst),
        .dp_rst (dp_rst),
        .ins    (ins),
        .push   (push),
        .pop    (pop),
        .modes  (modes),
        .cntup  (cntup),
        .n      (n),
        .lt     (lt),
        .empty  (empty),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts edges until done (cycle 1 = first edge after start is driven).
    // Returns -1 when the cycle budget runs out without a done.
    task automatic run(input int limit, input bit drop_start,
                       input int pulse_at, output int done_cyc);
        done_cyc    = -1;
        pushes      = 0;
        pops        = 0;
        busy_lows   = 0;
        res_at_done = -1;
        for (int i = 1; i <= 16; i++) trace[i] = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (drop_start && c == 1) start = 1'b0;
            if (pulse_at > 0 && c == pulse_at) start = 1'b1;
            if (pulse_at > 0 && c == pulse_at + 1) start = 1'b0;
            if (c <= 16) trace[c] = int'(ctl);
            pushes += int'(push);
            pops   += int'(pop);
            if (!busy) busy_lows++;
            if (done) begin
                done_cyc    = c;
                res_at_done = int'(result);
                break;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        n     = 3'd0;

        #12;
        check("reset ctl", int'(ctl), C_IDLE);
        #8;
        rst = 1'b0;
        @(negedge clk);
        check("idle ctl", int'(ctl), C_IDLE);

        // n=0: single leaf
        n = 3'd0; start = 1'b1;
        run(40, 1'b1, 0, dc);
        check("n0 latency", dc, 6);
        check("n0 result", res_at_done, 0);
        check("n0 pushes", pushes, 1);
        check("n0 pops", pops, 1);
        check("n0 clear", trace[1], C_CLEAR);
        check("n0 leaf", trace[4], C_LEAF);
        check("n0 done ctl", trace[6], C_DONE);
        @(negedge clk);
        check("n0 done width", int'(ctl), C_IDLE);

        // n=3: trace of first expansion
        n = 3'd3; start = 1'b1;
        run(60, 1'b1, 0, dc);
        check("n3 latency", dc, 18);
        check("n3 result", res_at_done, 2);
        check("n3 init", trace[2], C_INIT);
        check("n3 check", trace[3], C_CHECK);
        check("n3 exp_pop", trace[4], C_POP);
        check("n3 exp_a", trace[5], C_EXPA);
        check("n3 exp_b", trace[6], C_EXPB);
        check("n3 check2", trace[7], C_CHECK);
        check("n3 leaf", trace[8], C_LEAF);
        check("n3 pushes", pushes, 5);
        check("n3 pops", pops, 5);
        @(negedge clk);

        // n=7: largest operand
        n = 3'd7; start = 1'b1;
        run(200, 1'b1, 0, dc);
        check("n7 latency", dc, 126);
        check("n7 result", res_at_done, 13);
        check("n7 busy lows", busy_lows, 0);
        check("n7 pushes", pushes, 41);
        check("n7 pops", pops, 41);
        @(negedge clk);

        // n=5: extra start while busy is dropped, not queued
        n = 3'd5; start = 1'b1;
        run(100, 1'b1, 10, dc);
        check("n5 latency", dc, 48);
        check("n5 result", res_at_done, 5);
        run(60, 1'b0, 0, dc);
        check("n5 no queued run", dc, -1);
        check("n5 idle busy", int'(busy), 0);

        // n=5 aborted by reset at cycle 20
        n = 3'd5; start = 1'b1;
        run(20, 1'b1, 0, dc);
        check("abort early done", dc, -1);
        check("abort busy before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort async ctl", int'(ctl), C_IDLE);
        @(negedge clk);
        check("abort hold ctl", int'(ctl), C_IDLE);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort idle ctl", int'(ctl), C_IDLE);
        n = 3'd1; start = 1'b1;
        run(40, 1'b1, 0, dc);
        check("n1 latency", dc, 6);
        check("n1 result", res_at_done, 1);
        @(negedge clk);

        // n=3 with start held: back-to-back runs
        n = 3'd3; start = 1'b1;
        run(60, 1'b0, 0, dc);
        check("b2b first latency", dc, 18);
        check("b2b first result", res_at_done, 2);
        for (int r = 0; r < 2; r++) begin
            run(60, 1'b0, 0, dc);
            check("b2b period", dc, 19);
            check("b2b result", res_at_done, 2);
            check("b2b idle gap", trace[1], C_IDLE);
            check("b2b clear", trace[2], C_CLEAR);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b stop ctl", int'(ctl), C_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
